if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// tracking with redirect squashing, and a small {pc, instr} buffer to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

    logic [31:0]   entry_pc    [DEPTH];
    logic [31:0]   entry_instr [DEPTH];

    logic [SW-1:0] credit_used;
    logic [31:0]   redirect_target;
    logic          grant;
    logic          resp;
    logic          resp_keep;
    logic          resp_drop;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Every slot that is requested, dropping, or buffered holds one credit,
    // so a granted request always has room in the buffer when it returns.
    assign credit_used = SW'(outstanding_reg) + SW'(drop_reg) + SW'(count_reg);
    assign imem_req    = rst_n && !redirect_valid && (credit_used < SW'(DEPTH));
    assign imem_addr   = fetch_pc_reg;
    assign grant       = imem_req && imem_gnt;

    assign resp      = imem_rvalid && ((outstanding_reg != '0) || (drop_reg != '0));
    assign resp_drop = resp && (drop_reg != '0);
    assign resp_keep = resp && (drop_reg == '0);

    assign if_valid = (count_reg != '0);
    assign if_pc    = entry_pc[rd_ptr_reg];
    assign if_instr = entry_instr[rd_ptr_reg];

    assign pop  = if_valid && if_ready && !redirect_valid;
    assign push = resp_keep && !redirect_valid;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;

        if (redirect_valid) begin
            fetch_pc_next    = redirect_target;
            resp_pc_next     = redirect_target;
            outstanding_next = '0;
            // Anything still owed by memory becomes a response to discard.
            drop_next        = drop_reg + outstanding_reg - CW'(resp);
            count_next       = '0;
            rd_ptr_next      = '0;
            wr_ptr_next      = '0;
        end else begin
            if (grant) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (resp_keep) begin
                resp_pc_next = resp_pc_reg + 32'd4;
            end
            outstanding_next = outstanding_reg + CW'(grant) - CW'(resp_keep);
            drop_next        = drop_reg - CW'(resp_drop);
            count_next       = count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    // Buffer storage carries no reset; count_reg alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_pc[wr_ptr_reg]    <= resp_pc_reg;
            entry_instr[wr_ptr_reg] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: memory responder model, expected
// fetch-stream queue, and directed scenarios for reset, stall, redirect, wrap.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready;

    logic        w_rst_n, w_req, w_gnt, w_rvalid, w_valid, w_ready;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;

    if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    if_stage #(.RESET_PC(WRAP_PC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_ready(w_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        n_checks++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: condition false, expected true", name);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- memory responder model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t mq[$];
    int   cyc      = 0;
    int   lat_min  = 1;
    int   lat_max  = 1;
    bit   junk_en  = 1'b0;
    int   n_grants = 0;

    initial begin
        bit          resp_now;
        bit          g;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk); #1;
            resp_now = 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                resp_now    = 1'b1;
                imem_rvalid = 1'b1;
                imem_rdata  = hash(mq[0].addr);
            end else if (junk_en && mq.size() == 0 && $urandom_range(7) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            #1;
            g = imem_req && imem_gnt;
            a = imem_addr;
            @(posedge clk);
            cyc++;
            if (resp_now) void'(mq.pop_front());
            if (g) begin
                mq.push_back('{addr: a, due: cyc + int'($urandom_range(lat_max, lat_min))});
                n_grants++;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    // exp_q holds the next expected fetch address of the architectural stream;
    // stimulus re-seeds it on every redirect or reset.
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    int          pops = 0;

    initial begin
        bit          prev_hold, prev_wait, after_redir;
        logic [31:0] hold_pc, hold_instr, hold_addr, e;
        prev_hold = 1'b0; prev_wait = 1'b0; after_redir = 1'b0;
        hold_pc = '0; hold_instr = '0; hold_addr = '0;
        forever begin
            @(negedge clk); #3;
            if (!rst_n) begin
                check("reset_if_valid", {31'b0, if_valid}, 32'd0);
                check("reset_imem_req", {31'b0, imem_req}, 32'd0);
                prev_hold = 1'b0; prev_wait = 1'b0; after_redir = 1'b0;
            end else begin
                if (after_redir) check("if_valid_after_redirect", {31'b0, if_valid}, 32'd0);
                if (prev_hold) begin
                    check("hold_if_valid", {31'b0, if_valid}, 32'd1);
                    check("hold_if_pc", if_pc, hold_pc);
                    check("hold_if_instr", if_instr, hold_instr);
                end
                if (prev_wait && !redirect_valid) begin
                    check("wait_imem_req", {31'b0, imem_req}, 32'd1);
                    check("wait_imem_addr", imem_addr, hold_addr);
                end
                if (imem_req) check("imem_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                if (redirect_valid) begin
                    after_redir = 1'b1;
                    prev_hold   = 1'b0;
                    prev_wait   = 1'b0;
                end else begin
                    after_redir = 1'b0;
                    if (if_valid && if_ready) begin
                        if (exp_q.size() == 0) begin
                            check_true("pop_unexpected", 1'b0);
                        end else begin
                            e = exp_q.pop_front();
                            check("pop_pc", if_pc, e);
                            check("pop_instr", if_instr, hash(e));
                            exp_q.push_back(e + 32'd4);
                        end
                        pop_log.push_back(if_pc);
                        pops++;
                    end
                    prev_hold  = if_valid && !if_ready;
                    hold_pc    = if_pc;
                    hold_instr = if_instr;
                    prev_wait  = imem_req && !imem_gnt;
                    hold_addr  = imem_addr;
                end
            end
        end
    end

    // ---------------- wrap-around instance: fixed 1-cycle memory ----------------
    logic [31:0] w_pcs[$];
    logic [31:0] w_instrs[$];

    initial begin
        bit          wg, w_pend;
        logic [31:0] wa, w_pend_addr;
        w_rvalid = 1'b0; w_rdata = '0; w_pend = 1'b0; w_pend_addr = '0;
        forever begin
            @(negedge clk); #1;
            w_rvalid = w_pend;
            w_rdata  = hash(w_pend_addr);
            #1;
            wg = w_req && w_gnt;
            wa = w_addr;
            @(posedge clk);
            w_pend      = wg;
            w_pend_addr = wa;
        end
    end

    initial begin
        forever begin
            @(negedge clk); #3;
            if (w_rst_n && w_valid && w_ready && w_pcs.size() < 8) begin
                w_pcs.push_back(w_pc);
                w_instrs.push_back(w_instr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            step();
            k++;
        end
        check_true(name, pop_log.size() >= n);
    endtask

    task automatic quiesce(input string name);
        int k = 0;
        imem_gnt = 1'b0;
        if_ready = 1'b1;
        while ((mq.size() != 0 || if_valid) && k < 60) begin
            step();
            k++;
        end
        check_true(name, mq.size() == 0 && !if_valid);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        exp_q.delete();
        exp_q.push_back({target[31:2], 2'b00});
    endtask

    task automatic two_in_flight(input string name);
        int g0 = n_grants;
        int k  = 0;
        lat_min = 5; lat_max = 5;
        imem_gnt = 1'b1;
        while (n_grants - g0 < 2 && k < 10) begin
            step();
            k++;
        end
        check(name, n_grants - g0, 2);
    endtask

    initial begin
        int g0;
        int p0;
        rst_n = 1'b0; w_rst_n = 1'b0;
        imem_gnt = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        w_gnt = 1'b1; w_ready = 1'b1;
        exp_q.push_back(32'h0);
        repeat (3) step();
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);

        // Release with no grant: first request at RESET_PC, held while ungranted.
        step();
        rst_n = 1'b1; w_rst_n = 1'b1;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("nognt_req", {31'b0, imem_req}, 32'd1);
            check("nognt_addr", imem_addr, 32'h0);
            check("nognt_if_valid", {31'b0, if_valid}, 32'd0);
        end

        // Decode stalled for 10 cycles: credits cap grants at DEPTH.
        pop_log.delete();
        lat_min = 1; lat_max = 1;
        if_ready = 1'b0; imem_gnt = 1'b1;
        g0 = n_grants;
        repeat (10) step();
        check("stall_grants", n_grants - g0, 2);
        check("stall_req_off", {31'b0, imem_req}, 32'd0);
        check("stall_if_pc", if_pc, 32'h0);
        check("stall_if_instr", if_instr, hash(32'h0));

        // Streaming: with the credit rule at DEPTH 2 and 1-cycle memory the
        // sustained rate is two instructions per three cycles.
        if_ready = 1'b1;
        p0 = pops;
        repeat (30) step();
        check_true("stream_rate", pops - p0 >= 15);
        check_true("stream_len", pop_log.size() >= 3);
        for (int i = 0; i < 3; i++)
            check("stream_pc", (i < pop_log.size()) ? pop_log[i] : 32'hBAD0_0000, 32'(i * 4));

        // Redirect with two responses outstanding.
        quiesce("quiesce_a");
        pop_log.delete();
        two_in_flight("inflight_a");
        redirect(32'h0000_0103);
        step();
        redirect_valid = 1'b0;
        check("redir_if_valid", {31'b0, if_valid}, 32'd0);
        wait_pops(1, 60, "redir_pop_timeout");
        check("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hBAD0_0000, 32'h0000_0100);

        // Back-to-back redirects: the second target wins.
        quiesce("quiesce_b");
        pop_log.delete();
        two_in_flight("inflight_b");
        redirect(32'h0000_0200);
        step();
        redirect(32'h0000_0303);
        step();
        redirect_valid = 1'b0;
        check("b2b_if_valid", {31'b0, if_valid}, 32'd0);
        wait_pops(1, 60, "b2b_pop_timeout");
        check("b2b_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hBAD0_0000, 32'h0000_0300);

        // Mid-operation reset with one buffered and one in-flight instruction.
        quiesce("quiesce_c");
        if_ready = 1'b0;
        lat_min = 1; lat_max = 1;
        g0 = n_grants;
        imem_gnt = 1'b1;
        begin
            int k = 0;
            while (n_grants == g0 && k < 10) begin step(); k++; end
        end
        lat_min = 6; lat_max = 6;
        begin
            int k = 0;
            while (!if_valid && k < 10) begin step(); k++; end
        end
        check("prereset_if_valid", {31'b0, if_valid}, 32'd1);
        rst_n = 1'b0;
        imem_gnt = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        #1;
        check("async_if_valid", {31'b0, if_valid}, 32'd0);
        check("async_imem_req", {31'b0, imem_req}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("rerst_req", {31'b0, imem_req}, 32'd1);
        check("rerst_addr", imem_addr, 32'h0);
        begin
            int k = 0;
            while (mq.size() != 0 && k < 20) begin step(); k++; end
            check_true("stale_drained", mq.size() == 0);
        end
        step();
        check("stale_ignored", {31'b0, if_valid}, 32'd0);
        pop_log.delete();
        if_ready = 1'b1;
        lat_min = 1; lat_max = 3;
        imem_gnt = 1'b1;
        wait_pops(1, 30, "rerst_pop_timeout");
        check("rerst_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hBAD0_0000, 32'h0);

        // Randomized traffic.
        lat_min = 1; lat_max = 4;
        junk_en = 1'b1;
        p0 = pops;
        for (int i = 0; i < 2000; i++) begin
            step();
            if_ready = ($urandom_range(3) != 0);
            imem_gnt = ($urandom_range(3) != 0);
            if ($urandom_range(29) == 0) redirect($urandom);
            else redirect_valid = 1'b0;
        end
        step();
        redirect_valid = 1'b0;
        junk_en = 1'b0;
        quiesce("quiesce_rand");
        check_true("rand_progress", pops - p0 > 200);

        // Wrap-around instance.
        check_true("wrap_count", w_pcs.size() >= 3);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] e;
            e = WRAP_PC + 32'(i * 4);
            check("wrap_pc", (i < w_pcs.size()) ? w_pcs[i] : 32'hBAD0_0000, e);
            check("wrap_instr", (i < w_instrs.size()) ? w_instrs[i] : 32'hBAD0_0000, hash(e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
